// File: rtl/pulse_hold_pkg.sv
// Shared types for the pulse_hold event-to-level converter.
package pulse_hold_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_LOW = 2'd2
    } ph_state_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of queued events; flags an increment that cannot be stored.
module pend_counter #(
    parameter int unsigned MAX = 7,
    parameter int unsigned W   = 3
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         drop
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    // Simultaneous inc and dec cancel, so a full counter can still accept while launching.
    assign drop = inc && !dec && (count == MAXV);

    always_ff @(posedge CLK) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != MAXV) begin
                count <= count + W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_hold.sv
// Converts single-cycle event pulses into a held request level with a four-phase
// req/ack handshake; events arriving mid-handshake are queued and replayed in order.
module pulse_hold
    import pulse_hold_pkg::*;
#(
    parameter int unsigned  HOLD_CYCLES = 4,
    parameter int unsigned  MAX_PENDING = 7,
    localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          x,
    input  logic          ack,
    output logic          y,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int unsigned HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    ph_state_t     state;
    logic [HW-1:0] hold;
    logic          launch;
    logic          inc;
    logic          dec;
    logic          drop;

    // An event in IDLE with an empty queue launches directly instead of being counted.
    assign launch = (state == IDLE) && (x || (pending != '0));
    assign inc    = x && !((state == IDLE) && (pending == '0));
    assign dec    = (state == IDLE) && (pending != '0);
    assign busy   = (state != IDLE);

    pend_counter #(
        .MAX (MAX_PENDING),
        .W   (PW)
    ) u_pend (
        .CLK   (CLK),
        .reset (reset),
        .inc   (inc),
        .dec   (dec),
        .count (pending),
        .drop  (drop)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            y        <= 1'b0;
            hold     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | drop;
            case (state)
                IDLE: begin
                    if (launch) begin
                        y     <= 1'b1;
                        hold  <= HOLD_INIT;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if ((hold == '0) && ack) begin
                        y     <= 1'b0;
                        state <= WAIT_LOW;
                    end else if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    y     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_hold.sv
// Self-checking bench for pulse_hold: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_pulse_hold;

    localparam int HOLD = 4;
    localparam int MAXP = 7;
    localparam int PW   = 3;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          x = 1'b0;
    logic          ack = 1'b0;
    logic          y;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_hold #(
        .HOLD_CYCLES (HOLD),
        .MAX_PENDING (MAXP)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .x        (x),
        .ack      (ack),
        .y        (y),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: y level, "waiting for ack to drop" flag, cycles y has been high, queue depth.
    bit m_y  = 0;
    bit m_wl = 0;
    bit m_ovf = 0;
    int m_pend = 0;
    int m_el = 0;

    int   y_rises = 0;
    logic y_prev = 1'b0;

    typedef struct {
        bit r;
        bit xi;
        bit ai;
        bit ey;
        bit eb;
        int ep;
        bit eo;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit xi, input bit ai);
        if (r) begin
            m_y = 0; m_wl = 0; m_pend = 0; m_ovf = 0; m_el = 0;
        end else if (!m_y && !m_wl) begin
            if (xi || m_pend > 0) begin
                if (!xi) m_pend--;
                m_y  = 1;
                m_el = 1;
            end
        end else begin
            if (xi) begin
                if (m_pend < MAXP) m_pend++;
                else m_ovf = 1;
            end
            if (m_y) begin
                if (m_el >= HOLD && ai) begin
                    m_y  = 0;
                    m_wl = 1;
                end else begin
                    m_el++;
                end
            end else if (!ai) begin
                m_wl = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit xi, input bit ai);
        @(negedge CLK);
        reset = r;
        x     = xi;
        ack   = ai;
        @(posedge CLK);
        model_step(r, xi, ai);
        #1;
        if (y && !y_prev) y_rises++;
        y_prev = y;
        chk("y", 32'(y), 32'(m_y));
        chk("busy", 32'(busy), 32'(m_y | m_wl));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Consumer that acknowledges while y is high and releases once it drops.
    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 400; k++) begin
            if (!busy && pending == '0) begin
                done = 1;
                break;
            end
            cyc(0, 0, y);
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int hi_cnt;
        int wl_cnt;
        int rises_before;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 1, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 1, 1, 0};
        tbl[10] = '{0, 1, 0, 1, 1, 2, 0};
        tbl[11] = '{0, 1, 0, 1, 1, 3, 0};
        tbl[12] = '{0, 0, 1, 0, 1, 3, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 3, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 2, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].xi, tbl[i].ai);
            chk("tbl_y", 32'(y), 32'(tbl[i].ey));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
            chk("tbl_pending", 32'(pending), 32'(tbl[i].ep));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].eo));
        end
        drain();
        chk("queue_drained", 32'(pending), 32'd0);

        // Slow ack: 11 high cycles, then 3 cycles waiting for ack to drop.
        cyc(1, 0, 0);
        hi_cnt = 0;
        wl_cnt = 0;
        cyc(0, 1, 0);
        if (y) hi_cnt++;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0);
            if (y) hi_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            if (y) hi_cnt++;
            if (busy && !y) wl_cnt++;
        end
        cyc(0, 0, 0);
        if (busy && !y) wl_cnt++;
        chk("slow_high_cycles", 32'(hi_cnt), 32'd11);
        chk("slow_waitlow_cycles", 32'(wl_cnt), 32'd3);
        chk("slow_idle", 32'(busy), 32'd0);

        // Overflow: 9 events while held high.
        cyc(1, 0, 0);
        y_rises = 0;
        cyc(0, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0);
        chk("ovf_pending", 32'(pending), 32'd7);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain();
        chk("ovf_pulses", 32'(y_rises), 32'd8);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full queue in IDLE plus a new event: launch and enqueue cancel out.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("full_idle_pending", 32'(pending), 32'd7);
        chk("full_idle_busy", 32'(busy), 32'd0);
        cyc(0, 1, 0);
        chk("simul_pending", 32'(pending), 32'd7);
        chk("simul_overflow", 32'(overflow), 32'd0);
        chk("simul_y", 32'(y), 32'd1);
        drain();

        // Reset while high with three queued events.
        cyc(0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        chk("pre_reset_pending", 32'(pending), 32'd3);
        cyc(1, 0, 1);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rises_before = y_rises;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        chk("rst_no_launch", 32'(y_rises), 32'(rises_before));
        cyc(0, 1, 1);
        chk("rst_new_launch", 32'(y), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, xi, ai;
            r  = ($urandom_range(0, 199) == 0);
            xi = ($urandom_range(0, 2) == 0);
            if (y) ai = ($urandom_range(0, 3) != 0);
            else   ai = ($urandom_range(0, 2) == 0);
            cyc(r, xi, ai);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
